// File: rtl/nvram_upload_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_upload_reader_if
//  Description : ioctl upload bus between the HPS side (master) and the
//                NVRAM upload reader (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface nvram_upload_reader_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        input  ioctl_din, ioctl_wait
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
        output ioctl_din, ioctl_wait
    );
endinterface
`default_nettype wire

// File: rtl/nvram_upload_reader.sv
`default_nettype none
// ============================================================================
//  Module      : nvram_upload_reader
//  Description : Returns NVRAM / high-score RAM bytes to the HPS during an
//                ioctl upload. Freezes the core via pause_req/pause_ack,
//                fetches each byte from a fixed-latency RAM port while
//                stalling the HPS with ioctl_wait, and keeps a dirty flag.
//                Optional macro NVRAM_CHECKSUM_EN appends a two's-complement
//                checksum byte at address SIZE.
//  Revision    : 1.0 - initial release
// ============================================================================
module nvram_upload_reader #(
    parameter int         AW      = 10,
    parameter int         SIZE    = 1024,
    parameter int         LATENCY = 2,
    parameter logic [7:0] INDEX   = 8'd4,
    parameter logic [7:0] FILL    = 8'hFF
) (
    input  wire logic                   clk_25,
    input  wire logic                   reset,
    nvram_upload_reader_if.slave        ioctl,
    output logic [AW-1:0]               mem_addr,
    output logic                        mem_rd,
    input  wire logic [7:0]             mem_dout,
    input  wire logic                   core_wr,
    output logic                        pause_req,
    input  wire logic                   pause_ack,
    output logic                        dirty,
    output logic                        upload_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        READY = 2'd2,
        FETCH = 2'd3
    } state_t;

    localparam logic [24:0] c_size = 25'(SIZE);

    state_t         r_state;
    state_t         w_next;
    logic [25:0]    r_count;
    logic [2:0]     r_lat;
    logic [7:0]     r_din;
    logic [AW-1:0]  r_mem_addr;
    logic           r_dirty;
    logic           r_done;
    logic           w_wait;
    logic           w_pause;
    logic           w_start;
    logic           w_rd_ready;
    logic           w_issue;
    logic           w_fill;
    logic           w_capture;
    logic           w_complete;
    logic [7:0]     w_fill_byte;

    assign w_start    = (r_state == IDLE) && ioctl.ioctl_upload && (ioctl.ioctl_index == INDEX);
    assign w_rd_ready = (r_state == READY) && ioctl.ioctl_upload && ioctl.ioctl_rd;
    assign w_issue    = w_rd_ready && (ioctl.ioctl_addr < c_size);
    assign w_fill     = w_rd_ready && !(ioctl.ioctl_addr < c_size);
    // The counter was loaded with LATENCY, so a value of 1 means it hits 0 on this edge
    assign w_capture  = (r_state == FETCH) && ioctl.ioctl_upload && (r_lat <= 3'd1);

`ifdef NVRAM_CHECKSUM_EN
    localparam logic [25:0] c_done_cnt = 26'(SIZE + 1);
    logic [7:0] r_sum;

    assign w_fill_byte = (ioctl.ioctl_addr == c_size) ? (~r_sum + 8'd1) : FILL;

    // Running modulo-256 sum of every byte fetched from RAM this session
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_sum <= 8'd0;
        end else if (w_start) begin
            r_sum <= 8'd0;
        end else if (w_capture) begin
            r_sum <= r_sum + mem_dout;
        end
    end
`else
    localparam logic [25:0] c_done_cnt = 26'(SIZE);

    assign w_fill_byte = FILL;
`endif

    assign w_complete = (r_state == READY) && !ioctl.ioctl_upload && (r_count >= c_done_cnt);

    // State register
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and combinational handshake outputs
    always_comb begin
        w_next  = r_state;
        w_wait  = 1'b0;
        w_pause = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = PAUSE;
                end
            end
            PAUSE: begin
                w_pause = 1'b1;
                w_wait  = 1'b1;
                if (!ioctl.ioctl_upload) begin
                    w_next = IDLE;
                end else if (pause_ack) begin
                    w_next = READY;
                end
            end
            READY: begin
                w_pause = 1'b1;
                w_wait  = ioctl.ioctl_rd;
                if (!ioctl.ioctl_upload) begin
                    w_next = IDLE;
                end else if (w_issue) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                w_pause = 1'b1;
                w_wait  = 1'b1;
                if (!ioctl.ioctl_upload) begin
                    w_next = IDLE;
                end else if (w_capture) begin
                    w_next = READY;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Byte counter, latency counter, returned byte and held RAM address
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_count    <= 26'd0;
            r_lat      <= 3'd0;
            r_din      <= 8'd0;
            r_mem_addr <= '0;
        end else begin
            if (w_start) begin
                r_count <= 26'd0;
            end else if ((w_fill || w_capture) && (r_count != '1)) begin
                r_count <= r_count + 26'd1;
            end

            if (w_issue) begin
                r_lat <= 3'(LATENCY);
            end else if ((r_state == FETCH) && (r_lat != 3'd0)) begin
                r_lat <= r_lat - 3'd1;
            end

            if (w_capture) begin
                r_din <= mem_dout;
            end else if (w_fill) begin
                r_din <= w_fill_byte;
            end

            if (w_issue) begin
                r_mem_addr <= ioctl.ioctl_addr[AW-1:0];
            end
        end
    end

    // Dirty flag and completion pulse; a core write beats a simultaneous clear
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            r_dirty <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_complete;
            if (core_wr) begin
                r_dirty <= 1'b1;
            end else if (w_complete) begin
                r_dirty <= 1'b0;
            end
        end
    end

    // The address is presented in the request cycle so the RAM latency starts there
    assign mem_rd          = w_issue;
    assign mem_addr        = w_issue ? ioctl.ioctl_addr[AW-1:0] : r_mem_addr;
    assign pause_req       = w_pause;
    assign ioctl.ioctl_wait = w_wait;
    assign ioctl.ioctl_din = r_din;
    assign dirty           = r_dirty;
    assign upload_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nvram_upload_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nvram_upload_reader
//  Description : Self-checking bench for nvram_upload_reader: vector table,
//                randomized reads against a transaction-level model, and
//                hand-written sequences for completion, abort and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nvram_upload_reader;

    localparam int         AW   = 10;
    localparam int         SIZE = 1024;
    localparam int         LAT  = 2;
    localparam logic [7:0] FILL = 8'hFF;

    logic           clk_25 = 1'b0;
    logic           reset;
    logic [AW-1:0]  mem_addr;
    logic           mem_rd;
    logic [7:0]     mem_dout;
    logic           core_wr;
    logic           pause_req;
    logic           pause_ack;
    logic           dirty;
    logic           upload_done;
    logic           ack_en;

    int n_checks = 0;
    int n_errors = 0;

    nvram_upload_reader_if bus();

    nvram_upload_reader #(
        .AW(AW), .SIZE(SIZE), .LATENCY(LAT), .INDEX(8'd4), .FILL(FILL)
    ) dut (
        .clk_25(clk_25), .reset(reset), .ioctl(bus.slave),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_dout(mem_dout),
        .core_wr(core_wr), .pause_req(pause_req), .pause_ack(pause_ack),
        .dirty(dirty), .upload_done(upload_done)
    );

    always #5 clk_25 = ~clk_25;

    // RAM: contents addr[7:0]^5A, read data emerges LAT cycles after mem_rd
    logic [7:0] ram  [0:SIZE-1];
    logic [7:0] pipe [0:LAT-1];
    always @(posedge clk_25) begin
        pipe[0] <= mem_rd ? ram[mem_addr] : 8'h00;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dout = pipe[LAT-1];

    // Core freezes one cycle after being asked, when allowed to
    always @(posedge clk_25 or posedge reset) begin
        if (reset) pause_ack <= 1'b0;
        else       pause_ack <= pause_req & ack_en;
    end

    // Transaction-level reference: byte and stall length per HPS read
    logic [7:0] model_sum;
    function automatic logic [7:0] ref_byte(input logic [24:0] a);
        logic [7:0] b;
        if (a < 25'(SIZE)) begin
            b = ram[a[AW-1:0]];
            model_sum = model_sum + b;
        end else begin
`ifdef NVRAM_CHECKSUM_EN
            b = (a == 25'(SIZE)) ? (8'd0 - model_sum) : FILL;
`else
            b = FILL;
`endif
        end
        return b;
    endfunction

    function automatic int ref_stall(input logic [24:0] a);
        return (a < 25'(SIZE)) ? LAT + 1 : 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hps_read(input logic [24:0] a, output logic [7:0] d, output int stall,
                            output int nrd, output logic [AW-1:0] rd_addr);
        stall = 0;
        nrd = 0;
        rd_addr = '0;
        @(posedge clk_25); #1;
        bus.ioctl_rd = 1'b1;
        bus.ioctl_addr = a;
        @(negedge clk_25);
        if (mem_rd) begin nrd++; rd_addr = mem_addr; end
        if (bus.ioctl_wait) stall++;
        @(posedge clk_25); #1;
        bus.ioctl_rd = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_25);
            if (mem_rd) nrd++;
            if (!bus.ioctl_wait) break;
            stall++;
        end
        d = bus.ioctl_din;
    endtask

    task automatic start_session();
        bit ok;
        ok = 1'b0;
        @(posedge clk_25); #1;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index = 8'd4;
        model_sum = 8'd0;
        repeat (2) @(negedge clk_25);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_25);
            if (pause_req && !bus.ioctl_wait) begin ok = 1'b1; break; end
        end
        check("session_ready", {31'd0, ok}, 32'd1);
    endtask

    // Reads 0..SIZE sequentially; returns how many reads disagreed with the model
    task automatic full_read(output int bad, output logic [7:0] last);
        logic [7:0] d, e;
        int st, nrd;
        logic [AW-1:0] ra;
        bad = 0;
        for (int a = 0; a <= SIZE; a++) begin
            hps_read(25'(a), d, st, nrd, ra);
            e = ref_byte(25'(a));
            if (d !== e || st != ref_stall(25'(a))) bad++;
        end
        last = d;
    endtask

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  exp_din;
        int          exp_stall;
        int          exp_rd;
    } vec_t;
    vec_t vecs [8];

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] d, e, held;
        int st, nrd, bad;
        logic [AW-1:0] ra;
        logic [24:0] a;

        vecs[0] = '{25'd3,        8'h59, 3, 1};
        vecs[1] = '{25'd0,        8'h5A, 3, 1};
        vecs[2] = '{25'd1023,     8'hA5, 3, 1};
        vecs[3] = '{25'd1025,     8'hFF, 1, 0};
        vecs[4] = '{25'd128,      8'hDA, 3, 1};
        vecs[5] = '{25'd2000,     8'hFF, 1, 0};
        vecs[6] = '{25'h1FFFFFF,  8'hFF, 1, 0};
        vecs[7] = '{25'd1,        8'h5B, 3, 1};

        for (int i = 0; i < SIZE; i++) ram[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < LAT; i++) pipe[i] = 8'h00;
        model_sum = 8'd0;

        // Reset with an upload already requested
        reset = 1'b1;
        ack_en = 1'b0;
        core_wr = 1'b0;
        bus.ioctl_upload = 1'b1;
        bus.ioctl_index = 8'd4;
        bus.ioctl_rd = 1'b0;
        bus.ioctl_addr = '0;
        repeat (3) @(negedge clk_25);
        check("rst_pause_req", {31'd0, pause_req}, 32'd0);
        check("rst_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        check("rst_din", {24'd0, bus.ioctl_din}, 32'd0);
        check("rst_dirty_done", {30'd0, dirty, upload_done}, 32'd0);
        check("rst_mem", {21'd0, mem_rd, mem_addr}, 32'd0);

        @(posedge clk_25); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk_25);
        check("pause_req", {31'd0, pause_req}, 32'd1);
        check("pause_wait", {31'd0, bus.ioctl_wait}, 32'd1);
        ack_en = 1'b1;
        repeat (3) @(negedge clk_25);
        check("ready_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        check("ready_pause_req", {31'd0, pause_req}, 32'd1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            hps_read(vecs[i].addr, d, st, nrd, ra);
            check($sformatf("vec%0d_din", i), {24'd0, d}, {24'd0, vecs[i].exp_din});
            check($sformatf("vec%0d_stall", i), st, vecs[i].exp_stall);
            check($sformatf("vec%0d_memrd", i), nrd, vecs[i].exp_rd);
            if (vecs[i].exp_rd == 1)
                check($sformatf("vec%0d_memaddr", i), {22'd0, ra}, {22'd0, vecs[i].addr[AW-1:0]});
        end
        held = bus.ioctl_din;
        repeat (3) @(negedge clk_25);
        check("din_hold", {24'd0, bus.ioctl_din}, {24'd0, held});

        // Randomized reads with sporadic core writes
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(4) == 0) a = 25'(SIZE + 1 + $urandom_range(30000));
            else                         a = 25'($urandom_range(SIZE - 1));
            hps_read(a, d, st, nrd, ra);
            e = ref_byte(a);
            check("rand_din", {24'd0, d}, {24'd0, e});
            check("rand_stall", st, ref_stall(a));
            repeat ($urandom_range(3)) @(posedge clk_25);
            if (i == 30 || $urandom_range(9) == 0) begin
                @(posedge clk_25); #1; core_wr = 1'b1;
                @(posedge clk_25); #1; core_wr = 1'b0;
            end
        end
        @(negedge clk_25);
        check("dirty_set", {31'd0, dirty}, 32'd1);

        // Incomplete upload ends: no done, dirty kept
        @(posedge clk_25); #1; bus.ioctl_upload = 1'b0;
        @(negedge clk_25);
        @(negedge clk_25);
        check("partial_done", {31'd0, upload_done}, 32'd0);
        check("partial_dirty", {31'd0, dirty}, 32'd1);
        check("partial_pause", {31'd0, pause_req}, 32'd0);

        // Complete upload: done pulse, dirty cleared
        start_session();
        full_read(bad, d);
        check("full_read_bad", bad, 0);
        check("full_dirty_before", {31'd0, dirty}, 32'd1);
        @(posedge clk_25); #1; bus.ioctl_upload = 1'b0;
        @(negedge clk_25);
        check("complete_done_early", {31'd0, upload_done}, 32'd0);
        @(negedge clk_25);
        check("complete_done", {31'd0, upload_done}, 32'd1);
        check("complete_dirty", {31'd0, dirty}, 32'd0);
        check("complete_pause", {31'd0, pause_req}, 32'd0);
        @(negedge clk_25);
        check("complete_done_pulse", {31'd0, upload_done}, 32'd0);

        // Complete upload with a coincident core write: dirty must survive
        start_session();
        full_read(bad, d);
        check("full_read2_bad", bad, 0);
        check("coinc_dirty_before", {31'd0, dirty}, 32'd0);
        @(posedge clk_25); #1; bus.ioctl_upload = 1'b0; core_wr = 1'b1;
        @(posedge clk_25); #1; core_wr = 1'b0;
        @(negedge clk_25);
        check("coinc_done", {31'd0, upload_done}, 32'd1);
        check("coinc_dirty", {31'd0, dirty}, 32'd1);

        // Abort in FETCH after a full read: no done, dirty and din untouched
        start_session();
        full_read(bad, held);
        check("full_read3_bad", bad, 0);
        @(posedge clk_25); #1; bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd5;
        @(posedge clk_25); #1; bus.ioctl_rd = 1'b0; bus.ioctl_upload = 1'b0;
        @(negedge clk_25);
        check("abort_fetch_wait", {31'd0, bus.ioctl_wait}, 32'd1);
        st = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_25);
            if (upload_done) st++;
        end
        check("abort_done", st, 0);
        check("abort_dirty", {31'd0, dirty}, 32'd1);
        check("abort_pause", {31'd0, pause_req}, 32'd0);
        check("abort_din", {24'd0, bus.ioctl_din}, {24'd0, held});

        // Index mismatch is ignored
        @(posedge clk_25); #1; bus.ioctl_upload = 1'b1; bus.ioctl_index = 8'd2;
        repeat (4) @(posedge clk_25);
        #1; bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd7;
        @(negedge clk_25);
        check("mismatch_pause", {31'd0, pause_req}, 32'd0);
        check("mismatch_rd", {30'd0, mem_rd, bus.ioctl_wait}, 32'd0);
        @(posedge clk_25); #1; bus.ioctl_rd = 1'b0; bus.ioctl_upload = 1'b0;
        bus.ioctl_index = 8'd4;

        // Asynchronous reset in FETCH
        start_session();
        @(posedge clk_25); #1; bus.ioctl_rd = 1'b1; bus.ioctl_addr = 25'd7;
        @(posedge clk_25); #1; bus.ioctl_rd = 1'b0;
        check("rstfetch_wait_before", {31'd0, bus.ioctl_wait}, 32'd1);
        #2; reset = 1'b1;
        #1;
        check("rstfetch_wait", {31'd0, bus.ioctl_wait}, 32'd0);
        check("rstfetch_pause", {31'd0, pause_req}, 32'd0);
        check("rstfetch_din", {24'd0, bus.ioctl_din}, 32'd0);
        bus.ioctl_upload = 1'b0;
        @(posedge clk_25); #1; reset = 1'b0;
        repeat (2) @(negedge clk_25);
        check("rstfetch_idle", {30'd0, pause_req, bus.ioctl_wait}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
